// File: rtl/sdram_user_model.sv
// sdram_user_model
//
// Behavioural stand-in for the SDRAM controller's user-side port. Client
// write/read bursts are answered with the same handshake timing as the real
// controller. The storage behind them is an internal 16-bit word RAM. An init
// delay and periodic refresh blackouts are modelled, so client logic sees the
// same stalls it would see against real memory.
//
// Ports
//   clock            system clock, rising edge
//   rst_n            asynchronous active-low reset
//   sdram_wr_req     write burst request, held until the last ack
//   sdram_wr_addr    write burst start word address (low ADDR_W bits used)
//   sdwr_bytes       write burst length in words (0 is treated as 1)
//   sdram_wr_data    write word, sampled on each cycle that sdram_wr_ack is high
//   sdram_wr_ack     one pulse per accepted write word
//   sdram_rd_req     read burst request, held until the last ack
//   sdram_rd_addr    read burst start word address (low ADDR_W bits used)
//   sdrd_bytes       read burst length in words (0 is treated as 1)
//   sdram_rd_data    read word, valid while sdram_rd_ack is high, then holds
//   sdram_rd_ack     one pulse per returned read word
//   sdram_init_done  high once the init delay has elapsed
//   sdram_busy       high whenever the responder is not idle
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_INIT    | power-up delay, requests ignored
// S_IDLE    | waiting; refresh > write > read priority
// S_REFRESH | refresh blackout, no acks
// S_WR_WAIT | write accepted, counting down the ack latency
// S_WR_BURST| one wr_ack per cycle, RAM written each cycle
// S_RD_WAIT | read accepted, counting down the ack latency
// S_RD_BURST| one rd_ack per cycle, rd_data updated each cycle
// S_GAP     | single dead cycle after every burst

module sdram_user_model #(
    parameter int ADDR_W         = 10,
    parameter int ACK_DELAY      = 3,
    parameter int INIT_CYCLES    = 200,
    parameter int REFRESH_PERIOD = 780,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        sdram_wr_req,
    input  logic [23:0] sdram_wr_addr,
    input  logic [8:0]  sdwr_bytes,
    input  logic [15:0] sdram_wr_data,
    output logic        sdram_wr_ack,
    input  logic        sdram_rd_req,
    input  logic [23:0] sdram_rd_addr,
    input  logic [8:0]  sdrd_bytes,
    output logic [15:0] sdram_rd_data,
    output logic        sdram_rd_ack,
    output logic        sdram_init_done,
    output logic        sdram_busy
);

    localparam int CNT_W = 16;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_DELAY - 1);
    localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REFRESH_PERIOD - 1);
    localparam logic [CNT_W-1:0] RCYC_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_REFRESH,
        S_WR_WAIT,
        S_WR_BURST,
        S_RD_WAIT,
        S_RD_BURST,
        S_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  init_cnt, init_cnt_nxt;
    logic [CNT_W-1:0]  timer, timer_nxt;
    logic [CNT_W-1:0]  ref_cnt, ref_cnt_nxt;
    logic              refresh_due, refresh_due_nxt;
    logic              refresh_set;
    logic              init_done, init_done_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [8:0]        len_q, len_nxt;
    logic [15:0]       rd_data_nxt;
    logic              ram_we;

    logic [8:0]        wr_len;
    logic [8:0]        rd_len;
    logic [CNT_W-1:0]  burst_last;

    logic [15:0]       mem [0:DEPTH-1];

    // Only the low ADDR_W address bits select a RAM word.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{sdram_wr_addr[23:ADDR_W], sdram_rd_addr[23:ADDR_W]};

    // A zero-length request still transfers one word.
    assign wr_len     = (sdwr_bytes == 9'd0) ? 9'd1 : sdwr_bytes;
    assign rd_len     = (sdrd_bytes == 9'd0) ? 9'd1 : sdrd_bytes;
    assign burst_last = {{(CNT_W-9){1'b0}}, len_q} - CNT_W'(1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INIT;
            init_cnt      <= '0;
            timer         <= '0;
            ref_cnt       <= '0;
            refresh_due   <= 1'b0;
            init_done     <= 1'b0;
            addr          <= '0;
            len_q         <= '0;
            sdram_rd_data <= '0;
        end else begin
            state         <= state_nxt;
            init_cnt      <= init_cnt_nxt;
            timer         <= timer_nxt;
            ref_cnt       <= ref_cnt_nxt;
            refresh_due   <= refresh_due_nxt;
            init_done     <= init_done_nxt;
            addr          <= addr_nxt;
            len_q         <= len_nxt;
            sdram_rd_data <= rd_data_nxt;
        end
    end

    // RAM contents survive reset, which lets a client inspect data written
    // before an aborted burst.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[addr] <= sdram_wr_data;
        end
    end

    always_comb begin
        state_nxt       = state;
        init_cnt_nxt    = init_cnt;
        timer_nxt       = timer;
        ref_cnt_nxt     = ref_cnt;
        refresh_due_nxt = refresh_due;
        refresh_set     = 1'b0;
        init_done_nxt   = init_done;
        addr_nxt        = addr;
        len_nxt         = len_q;
        rd_data_nxt     = sdram_rd_data;
        ram_we          = 1'b0;

        // Refresh timer free-runs once init is done, regardless of state.
        if (init_done) begin
            if (ref_cnt == '0) begin
                refresh_set = 1'b1;
                ref_cnt_nxt = REF_LAST;
            end else begin
                ref_cnt_nxt = ref_cnt - CNT_W'(1);
            end
        end

        case (state)
            S_INIT: begin
                if (init_cnt == INIT_LAST) begin
                    state_nxt     = S_IDLE;
                    init_done_nxt = 1'b1;
                    ref_cnt_nxt   = REF_LAST;
                end else begin
                    init_cnt_nxt = init_cnt + CNT_W'(1);
                end
            end

            S_IDLE: begin
                if (refresh_due) begin
                    state_nxt       = S_REFRESH;
                    timer_nxt       = RCYC_LAST;
                    refresh_due_nxt = 1'b0;
                end else if (sdram_wr_req) begin
                    state_nxt = S_WR_WAIT;
                    timer_nxt = ACK_LAST;
                    addr_nxt  = sdram_wr_addr[ADDR_W-1:0];
                    len_nxt   = wr_len;
                end else if (sdram_rd_req) begin
                    state_nxt = S_RD_WAIT;
                    timer_nxt = ACK_LAST;
                    addr_nxt  = sdram_rd_addr[ADDR_W-1:0];
                    len_nxt   = rd_len;
                end
            end

            S_REFRESH: begin
                if (timer == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end

            S_WR_WAIT: begin
                if (timer == '0) begin
                    state_nxt = S_WR_BURST;
                    timer_nxt = burst_last;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end

            S_WR_BURST: begin
                ram_we   = 1'b1;
                addr_nxt = addr + ADDR_W'(1);
                if (timer == '0) begin
                    state_nxt = S_GAP;
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end

            // rd_data is registered, so each word is fetched on the edge that
            // starts its ack cycle.
            S_RD_WAIT: begin
                if (timer == '0) begin
                    state_nxt   = S_RD_BURST;
                    timer_nxt   = burst_last;
                    rd_data_nxt = mem[addr];
                    addr_nxt    = addr + ADDR_W'(1);
                end else begin
                    timer_nxt = timer - CNT_W'(1);
                end
            end

            S_RD_BURST: begin
                if (timer == '0) begin
                    state_nxt = S_GAP;
                end else begin
                    timer_nxt   = timer - CNT_W'(1);
                    rd_data_nxt = mem[addr];
                    addr_nxt    = addr + ADDR_W'(1);
                end
            end

            S_GAP: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_INIT;
            end
        endcase

        // A new refresh tick wins over the clear on REFRESH entry.
        if (refresh_set) begin
            refresh_due_nxt = 1'b1;
        end
    end

    assign sdram_wr_ack    = (state == S_WR_BURST);
    assign sdram_rd_ack    = (state == S_RD_BURST);
    assign sdram_init_done = init_done;
    assign sdram_busy      = (state != S_IDLE);

endmodule

// File: tb/tb_sdram_user_model.sv
`timescale 1ns/1ps
module tb_sdram_user_model;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdram_wr_req = 1'b0;
    logic [23:0] sdram_wr_addr = '0;
    logic [8:0]  sdwr_bytes = '0;
    logic [15:0] sdram_wr_data = '0;
    logic        sdram_wr_ack;
    logic        sdram_rd_req = 1'b0;
    logic [23:0] sdram_rd_addr = '0;
    logic [8:0]  sdrd_bytes = '0;
    logic [15:0] sdram_rd_data;
    logic        sdram_rd_ack;
    logic        sdram_init_done;
    logic        sdram_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;            // rising edges since rst_n release
    logic [15:0] rbuf [0:15];

    sdram_user_model #(
        .ADDR_W(10), .ACK_DELAY(3), .INIT_CYCLES(200),
        .REFRESH_PERIOD(780), .REFRESH_CYCLES(8)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr),
        .sdwr_bytes(sdwr_bytes), .sdram_wr_data(sdram_wr_data),
        .sdram_wr_ack(sdram_wr_ack),
        .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr),
        .sdrd_bytes(sdrd_bytes), .sdram_rd_data(sdram_rd_data),
        .sdram_rd_ack(sdram_rd_ack),
        .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Write burst; data word i is base+i. lat = edges from raising req to first ack.
    task automatic do_write(input logic [23:0] a, input logic [8:0] n, input logic [15:0] base,
                            output int acks, output int lat);
        int j;
        bit done;
        acks = 0; lat = -1; j = 0; done = 0;
        sdram_wr_addr = a; sdwr_bytes = n; sdram_wr_data = base; sdram_wr_req = 1'b1;
        while (!done && j < 1000) begin
            tick(1);
            j++;
            if (sdram_wr_ack) begin
                if (acks == 0) lat = j;
                sdram_wr_data = base + 16'(acks);
                acks++;
            end else if (acks > 0) begin
                done = 1;
            end
        end
        sdram_wr_req = 1'b0;
        tick(2);
    endtask

    task automatic do_read(input logic [23:0] a, input logic [8:0] n, output int acks, output int lat);
        int j;
        bit done;
        acks = 0; lat = -1; j = 0; done = 0;
        sdram_rd_addr = a; sdrd_bytes = n; sdram_rd_req = 1'b1;
        while (!done && j < 1000) begin
            tick(1);
            j++;
            if (sdram_rd_ack) begin
                if (acks == 0) lat = j;
                if (acks < 16) rbuf[acks] = sdram_rd_data;
                acks++;
            end else if (acks > 0) begin
                done = 1;
            end
        end
        sdram_rd_req = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        int early_ack, early_done, first_e, cnt, acks, lat;
        early_ack = 0; early_done = 0; first_e = -1; cnt = 0;
        rst_n = 1'b0;
        tick(3);
        n_checks++; if (sdram_wr_ack !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ack: got %b expected 0", sdram_wr_ack); end
        n_checks++; if (sdram_rd_ack !== 1'b0) begin n_fail++; $display("FAIL rst_rd_ack: got %b expected 0", sdram_rd_ack); end
        n_checks++; if (sdram_rd_data !== 16'h0000) begin n_fail++; $display("FAIL rst_rd_data: got %h expected 0000", sdram_rd_data); end
        n_checks++; if (sdram_init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done: got %b expected 0", sdram_init_done); end
        n_checks++; if (sdram_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", sdram_busy); end

        // wr_req held through INIT must not be accepted before init_done
        sdram_wr_addr = 24'h000020; sdwr_bytes = 9'd1; sdram_wr_data = 16'h5555; sdram_wr_req = 1'b1;
        rst_n = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (sdram_wr_ack) early_ack++;
            if (i < 200 && sdram_init_done) early_done++;
        end
        n_checks++; if (early_done !== 0) begin n_fail++; $display("FAIL init_early: init_done high %0d cycles before edge 200", early_done); end
        n_checks++; if (sdram_init_done !== 1'b1) begin n_fail++; $display("FAIL init_edge200: got %b expected 1", sdram_init_done); end
        n_checks++; if (sdram_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", sdram_busy); end
        n_checks++; if (early_ack !== 0) begin n_fail++; $display("FAIL init_ack: got %0d acks during INIT expected 0", early_ack); end
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sdram_wr_ack) begin
                if (first_e < 0) first_e = ecnt;
                cnt++;
            end else if (cnt > 0) begin
                sdram_wr_req = 1'b0;
            end
        end
        sdram_wr_req = 1'b0;
        // accepted at edge 201, first ack after edge 201+3
        n_checks++; if (first_e !== 204) begin n_fail++; $display("FAIL init_wr_first: got edge %0d expected 204", first_e); end
        n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL init_wr_cnt: got %0d expected 1", cnt); end
        do_read(24'h000020, 9'd1, acks, lat);
        n_checks++; if (rbuf[0] !== 16'h5555) begin n_fail++; $display("FAIL init_wr_data: got %h expected 5555", rbuf[0]); end
    endtask

    task automatic test_write_read();
        int acks, lat;
        do_write(24'h000010, 9'd4, 16'hA001, acks, lat);
        n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL wr4_acks: got %0d expected 4", acks); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL wr4_lat: got %0d expected 4", lat); end
        do_read(24'h000010, 9'd4, acks, lat);
        n_checks++; if (acks !== 4) begin n_fail++; $display("FAIL rd4_acks: got %0d expected 4", acks); end
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL rd4_lat: got %0d expected 4", lat); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rbuf[i] !== 16'hA001 + 16'(i)) begin n_fail++; $display("FAIL rd4_data[%0d]: got %h expected %h", i, rbuf[i], 16'hA001 + 16'(i)); end
        end
        n_checks++; if (sdram_rd_data !== 16'hA004) begin n_fail++; $display("FAIL rd_data_hold: got %h expected a004", sdram_rd_data); end
    endtask

    task automatic test_wrap();
        int acks, lat;
        do_write(24'h0003FC, 9'd8, 16'hB000, acks, lat);
        n_checks++; if (acks !== 8) begin n_fail++; $display("FAIL wrap_wr_acks: got %0d expected 8", acks); end
        do_read(24'h0003FC, 9'd8, acks, lat);
        n_checks++; if (acks !== 8) begin n_fail++; $display("FAIL wrap_rd_acks: got %0d expected 8", acks); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rbuf[i] !== 16'hB000 + 16'(i)) begin n_fail++; $display("FAIL wrap_rd[%0d]: got %h expected %h", i, rbuf[i], 16'hB000 + 16'(i)); end
        end
        // 0x000400: upper bits ignored, lands on word 0 which the wrap wrote
        do_read(24'h000400, 9'd4, acks, lat);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (rbuf[i] !== 16'hB004 + 16'(i)) begin n_fail++; $display("FAIL wrap_low[%0d]: got %h expected %h", i, rbuf[i], 16'hB004 + 16'(i)); end
        end
    endtask

    task automatic test_simultaneous();
        int wr_cnt, rd_cnt, wr_first, rd_first, overlap, acks, lat;
        wr_cnt = 0; rd_cnt = 0; wr_first = -1; rd_first = -1; overlap = 0;
        sdram_wr_addr = 24'h000040; sdwr_bytes = 9'd2; sdram_wr_data = 16'hC000; sdram_wr_req = 1'b1;
        sdram_rd_addr = 24'h000010; sdrd_bytes = 9'd2; sdram_rd_req = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            if (sdram_wr_ack && sdram_rd_ack) overlap++;
            if (sdram_wr_ack) begin
                if (wr_cnt == 0) wr_first = j;
                sdram_wr_data = 16'hC000 + 16'(wr_cnt);
                wr_cnt++;
            end else if (wr_cnt > 0) begin
                sdram_wr_req = 1'b0;
            end
            if (sdram_rd_ack) begin
                if (rd_first < 0) rd_first = j;
                if (rd_cnt < 16) rbuf[rd_cnt] = sdram_rd_data;
                rd_cnt++;
            end else if (rd_cnt > 0) begin
                sdram_rd_req = 1'b0;
            end
        end
        sdram_wr_req = 1'b0; sdram_rd_req = 1'b0;
        // write k=1: acks 4,5; GAP 6; IDLE 7; read accepted 8; acks 11,12
        n_checks++; if (wr_first !== 4) begin n_fail++; $display("FAIL sim_wr_first: got %0d expected 4", wr_first); end
        n_checks++; if (wr_cnt !== 2) begin n_fail++; $display("FAIL sim_wr_cnt: got %0d expected 2", wr_cnt); end
        n_checks++; if (rd_first !== 11) begin n_fail++; $display("FAIL sim_rd_first: got %0d expected 11", rd_first); end
        n_checks++; if (rd_cnt !== 2) begin n_fail++; $display("FAIL sim_rd_cnt: got %0d expected 2", rd_cnt); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL sim_overlap: got %0d expected 0", overlap); end
        n_checks++; if (rbuf[0] !== 16'hA001) begin n_fail++; $display("FAIL sim_rd0: got %h expected a001", rbuf[0]); end
        n_checks++; if (rbuf[1] !== 16'hA002) begin n_fail++; $display("FAIL sim_rd1: got %h expected a002", rbuf[1]); end
        tick(2);
        do_read(24'h000040, 9'd2, acks, lat);
        n_checks++; if (rbuf[0] !== 16'hC000 || rbuf[1] !== 16'hC001) begin
            n_fail++; $display("FAIL sim_wr_data: got %h %h expected c000 c001", rbuf[0], rbuf[1]);
        end
    endtask

    task automatic test_refresh();
        int acks, lat, rd_first, rd_last, rd_cnt, wr_first, wr_cnt, quiet, guard;
        rd_first = -1; rd_last = -1; rd_cnt = 0; wr_first = -1; wr_cnt = 0; quiet = 0; guard = 0;
        do_write(24'h000100, 9'd16, 16'hE000, acks, lat);
        n_checks++; if (acks !== 16) begin n_fail++; $display("FAIL ref_wr16_acks: got %0d expected 16", acks); end
        // refresh falls due at edge 980; read accepted at 975 has acks 978..993
        while (ecnt < 974 && guard < 2000) begin tick(1); guard++; end
        sdram_rd_addr = 24'h000100; sdrd_bytes = 9'd16; sdram_rd_req = 1'b1;
        while (ecnt < 1012 && guard < 4000) begin
            tick(1);
            guard++;
            if (ecnt == 976) begin
                sdram_wr_addr = 24'h000050; sdwr_bytes = 9'd0; sdram_wr_data = 16'hD00D; sdram_wr_req = 1'b1;
            end
            if (sdram_rd_ack) begin
                if (rd_first < 0) rd_first = ecnt;
                rd_last = ecnt;
                if (rd_cnt < 16) rbuf[rd_cnt] = sdram_rd_data;
                rd_cnt++;
            end else if (rd_cnt > 0) begin
                sdram_rd_req = 1'b0;
            end
            if (sdram_wr_ack) begin
                if (wr_first < 0) wr_first = ecnt;
                wr_cnt++;
            end else if (wr_cnt > 0) begin
                sdram_wr_req = 1'b0;
            end
            if (ecnt >= 996 && ecnt <= 1003 && sdram_busy && !sdram_wr_ack && !sdram_rd_ack) quiet++;
        end
        sdram_rd_req = 1'b0; sdram_wr_req = 1'b0;
        n_checks++; if (rd_first !== 978) begin n_fail++; $display("FAIL ref_rd_first: got %0d expected 978", rd_first); end
        n_checks++; if (rd_last !== 993) begin n_fail++; $display("FAIL ref_rd_last: got %0d expected 993", rd_last); end
        n_checks++; if (rd_cnt !== 16) begin n_fail++; $display("FAIL ref_rd_cnt: got %0d expected 16", rd_cnt); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (rbuf[i] !== 16'hE000 + 16'(i)) begin n_fail++; $display("FAIL ref_rd[%0d]: got %h expected %h", i, rbuf[i], 16'hE000 + 16'(i)); end
        end
        n_checks++; if (quiet !== 8) begin n_fail++; $display("FAIL ref_blackout: got %0d quiet busy cycles expected 8", quiet); end
        // refresh 996..1003, IDLE 1004, write accepted 1005, ack after 1008
        n_checks++; if (wr_first !== 1008) begin n_fail++; $display("FAIL ref_wr_first: got %0d expected 1008", wr_first); end
        n_checks++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL len0_acks: got %0d expected 1", wr_cnt); end
        n_checks++; if (sdram_busy !== 1'b0) begin n_fail++; $display("FAIL ref_idle_busy: got %b expected 0", sdram_busy); end
        do_read(24'h000050, 9'd0, acks, lat);
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL len0_rd_acks: got %0d expected 1", acks); end
        n_checks++; if (rbuf[0] !== 16'hD00D) begin n_fail++; $display("FAIL len0_data: got %h expected d00d", rbuf[0]); end
    endtask

    task automatic test_reset_mid_burst();
        int cnt, j, acks, lat, rise;
        cnt = 0; j = 0; rise = -1;
        sdram_wr_addr = 24'h000200; sdwr_bytes = 9'd6; sdram_wr_data = 16'hF000; sdram_wr_req = 1'b1;
        while (cnt < 3 && j < 50) begin
            tick(1);
            j++;
            if (sdram_wr_ack) begin
                sdram_wr_data = 16'hF000 + 16'(cnt);
                cnt++;
            end
        end
        n_checks++; if (cnt !== 3) begin n_fail++; $display("FAIL mid_reach3: got %0d acks expected 3", cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (sdram_wr_ack !== 1'b0) begin n_fail++; $display("FAIL mid_wr_ack: got %b expected 0", sdram_wr_ack); end
        n_checks++; if (sdram_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", sdram_busy); end
        n_checks++; if (sdram_init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done: got %b expected 0", sdram_init_done); end
        sdram_wr_req = 1'b0;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 300 && rise < 0; i++) begin
            tick(1);
            if (sdram_init_done) rise = ecnt;
        end
        n_checks++; if (rise !== 200) begin n_fail++; $display("FAIL reinit_edge: got %0d expected 200", rise); end
        do_read(24'h000200, 9'd2, acks, lat);
        n_checks++; if (acks !== 2) begin n_fail++; $display("FAIL mid_rd_acks: got %0d expected 2", acks); end
        n_checks++; if (rbuf[0] !== 16'hF000) begin n_fail++; $display("FAIL mid_rd0: got %h expected f000", rbuf[0]); end
        n_checks++; if (rbuf[1] !== 16'hF001) begin n_fail++; $display("FAIL mid_rd1: got %h expected f001", rbuf[1]); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_simultaneous();
        test_refresh();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
